// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter.
//
// Accepts a WIDTH-bit pattern plus a repeat count through a valid/ready load
// handshake and shifts it out MSB-first, one qualified bit per cycle. The
// frame is repeated repeat_cnt extra times, with GAP idle cycles between
// frames. A one-cycle done pulse follows the final bit of the final frame.
//
// Handshake: a load is accepted on a rising edge where load_valid and
// load_ready are both high. load_ready is high only in IDLE and is never
// high while busy. Loads offered while busy are dropped, not queued.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   load_valid  pattern/repeat offered
//   load_ready  block accepts a load this cycle
//   pattern     pattern to send, sampled on accept
//   repeat_cnt  extra repetitions (frames = repeat_cnt + 1)
//   bit_out     serial data, MSB first (0 when bit_valid is low)
//   bit_valid   bit_out carries a frame bit
//   busy        high in SEND, GAP and DONE
//   done        one-cycle pulse after the final bit
//   dbg_state   current FSM state (0 IDLE, 1 SEND, 2 GAP, 3 DONE)
module pattern_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    // Remembers that reset was high last cycle so load_ready stays low
    // until the cycle after reset is released, without a path from rst.
    logic             r_rst_q;

    state_t           w_state;
    logic [WIDTH-1:0] w_hold;
    logic [WIDTH-1:0] w_shift;
    logic [BW-1:0]    w_bit_cnt;
    logic [GW-1:0]    w_gap_cnt;
    logic [CNT_W-1:0] w_rep_cnt;
    logic             w_load_ready;

    assign w_load_ready = (r_state == S_IDLE) && !r_rst_q;

    always_comb begin
        w_state   = r_state;
        w_hold    = r_hold;
        w_shift   = r_shift;
        w_bit_cnt = r_bit_cnt;
        w_gap_cnt = r_gap_cnt;
        w_rep_cnt = r_rep_cnt;
        case (r_state)
            S_IDLE: begin
                if (load_valid && w_load_ready) begin
                    w_hold    = pattern;
                    w_shift   = pattern;
                    w_rep_cnt = repeat_cnt;
                    w_bit_cnt = BIT_LAST;
                    w_state   = S_SEND;
                end
            end
            S_SEND: begin
                w_shift   = r_shift << 1;
                w_bit_cnt = r_bit_cnt - BW'(1);
                if (r_bit_cnt == '0) begin
                    if (r_rep_cnt != '0) begin
                        if (GAP > 0) begin
                            w_state   = S_GAP;
                            w_gap_cnt = GAP_LAST;
                        end else begin
                            // Back-to-back frames: reload with no bubble.
                            w_shift   = r_hold;
                            w_rep_cnt = r_rep_cnt - CNT_W'(1);
                            w_bit_cnt = BIT_LAST;
                        end
                    end else begin
                        w_state = S_DONE;
                    end
                end
            end
            S_GAP: begin
                w_gap_cnt = r_gap_cnt - GW'(1);
                if (r_gap_cnt == '0) begin
                    w_shift   = r_hold;
                    w_rep_cnt = r_rep_cnt - CNT_W'(1);
                    w_bit_cnt = BIT_LAST;
                    w_state   = S_SEND;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_rep_cnt <= '0;
            r_rst_q   <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_hold    <= w_hold;
            r_shift   <= w_shift;
            r_bit_cnt <= w_bit_cnt;
            r_gap_cnt <= w_gap_cnt;
            r_rep_cnt <= w_rep_cnt;
            r_rst_q   <= 1'b0;
        end
    end

    assign load_ready = w_load_ready;
    assign bit_valid  = (r_state == S_SEND);
    assign bit_out    = (r_state == S_SEND) && r_shift[WIDTH-1];
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pattern_tx.sv
module tb_pattern_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters (GAP=2). Instance B: GAP=0.
    logic       rst;
    logic       lv_a, lr_a, bo_a, bv_a, busy_a, done_a;
    logic [3:0] pat_a, rep_a;
    logic [1:0] st_a;
    logic       lv_b, lr_b, bo_b, bv_b, busy_b, done_b;
    logic [3:0] pat_b, rep_b;
    logic [1:0] st_b;

    pattern_tx #(.WIDTH(4), .GAP(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a),
        .pattern(pat_a), .repeat_cnt(rep_a), .bit_out(bo_a), .bit_valid(bv_a),
        .busy(busy_a), .done(done_a), .dbg_state(st_a)
    );

    pattern_tx #(.WIDTH(4), .GAP(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b),
        .pattern(pat_b), .repeat_cnt(rep_b), .bit_out(bo_b), .bit_valid(bv_b),
        .busy(busy_b), .done(done_b), .dbg_state(st_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed outputs packed as {load_ready, busy, done, bit_valid, bit_out}.
    function automatic logic [4:0] obs(input bit sel);
        return sel ? {lr_b, busy_b, done_b, bv_b, bo_b}
                   : {lr_a, busy_a, done_a, bv_a, bo_a};
    endfunction

    // Reference model: expected per-cycle outputs from the cycle after accept,
    // built frame by frame. Entry = {last_bit_of_frame, ready, busy, done, valid, bit}.
    // Sends one transaction, checks every cycle, the loopback window after each
    // frame, and the done latency. With corrupt set, the inputs are scrambled
    // and load_valid is pulsed while busy.
    task automatic send(input bit sel, input logic [3:0] pat, input logic [3:0] rep,
                        input bit corrupt, input int exp_lat);
        logic [5:0] exp_q[$];
        logic [5:0] e;
        logic [4:0] o;
        logic [3:0] window;
        int gap;
        int idx;
        int done_at;
        int frames_seen;
        gap = sel ? 0 : 2;
        for (int f = 0; f <= int'(rep); f++) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back({i == 0, 1'b0, 1'b1, 1'b0, 1'b1, pat[i]});
            if (f < int'(rep))
                for (int g = 0; g < gap; g++) exp_q.push_back(6'b0_01000);
        end
        exp_q.push_back(6'b0_01100);
        exp_q.push_back(6'b0_10000);

        @(negedge clk);
        if (sel) begin pat_b = pat; rep_b = rep; lv_b = 1'b1; end
        else     begin pat_a = pat; rep_a = rep; lv_a = 1'b1; end
        check("ready_before_accept", 32'(obs(sel) >> 4), 32'd1);
        @(posedge clk);
        @(negedge clk);
        window = 4'h0;
        idx = 0;
        done_at = -1;
        frames_seen = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs(sel);
            if (sel) begin
                lv_b = corrupt && e[3];
                if (corrupt) begin pat_b = 4'h0; rep_b = 4'hF; end
            end else begin
                lv_a = corrupt && e[3];
                if (corrupt) begin pat_a = 4'h0; rep_a = 4'hF; end
            end
            check($sformatf("cycle%0d_outputs", idx + 1), 32'(o), 32'(e[4:0]));
            if (o[1]) window = {window[2:0], o[0]};
            if (e[5]) begin
                frames_seen++;
                check("loopback_window", 32'(window), 32'(pat));
            end
            if (o[2] && done_at < 0) done_at = idx + 1;
            idx++;
            @(negedge clk);
        end
        check("done_latency", 32'(done_at), 32'(exp_lat));
        check("frames_seen", 32'(frames_seen), 32'(rep) + 1);
        if (sel) lv_b = 1'b0; else lv_a = 1'b0;
    endtask

    typedef struct {
        bit         sel;
        logic [3:0] pat;
        logic [3:0] rep;
        bit         corrupt;
        int         lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, 4'b1011, 4'd0,  1'b0, 5};
        tbl[1] = '{1'b0, 4'b1100, 4'd2,  1'b0, 17};
        tbl[2] = '{1'b1, 4'b0110, 4'd1,  1'b0, 9};
        tbl[3] = '{1'b0, 4'b1011, 4'd0,  1'b1, 5};
        tbl[4] = '{1'b0, 4'b1111, 4'd15, 1'b0, 95};
        tbl[5] = '{1'b1, 4'b0001, 4'd15, 1'b1, 65};
        tbl[6] = '{1'b0, 4'b1010, 4'd3,  1'b1, 23};

        rst = 1'b1;
        lv_a = 1'b1; pat_a = 4'hF; rep_a = 4'd0;
        lv_b = 1'b1; pat_b = 4'hF; rep_b = 4'd0;

        // Reset held three cycles with a load offered.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready_a", 32'(lr_a), 32'd0);
            check("rst_valid_a", 32'(bv_a), 32'd0);
            check("rst_busy_a",  32'(busy_a), 32'd0);
            check("rst_done_a",  32'(done_a), 32'd0);
            check("rst_bit_a",   32'(bo_a), 32'd0);
            check("rst_ready_b", 32'(lr_b), 32'd0);
        end
        rst = 1'b0;
        lv_a = 1'b0;
        lv_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_ready_a", 32'(lr_a), 32'd1);
            check("post_rst_valid_a", 32'(bv_a), 32'd0);
            check("post_rst_busy_a",  32'(busy_a), 32'd0);
            check("post_rst_ready_b", 32'(lr_b), 32'd1);
        end

        // Directed table.
        foreach (tbl[i]) send(tbl[i].sel, tbl[i].pat, tbl[i].rep, tbl[i].corrupt, tbl[i].lat);

        // Reset mid-frame after two bits of 1011.
        @(negedge clk);
        pat_a = 4'b1011; rep_a = 4'd0; lv_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv_a = 1'b0;
        check("abort_bit1", 32'({bv_a, bo_a}), 32'b11);
        @(negedge clk);
        check("abort_bit2", 32'({bv_a, bo_a}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(bv_a), 32'd0);
        check("abort_busy",  32'(busy_a), 32'd0);
        check("abort_done",  32'(done_a), 32'd0);
        check("abort_ready_in_rst", 32'(lr_a), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_after_ready", 32'(lr_a), 32'd1);
            check("abort_after_done",  32'(done_a), 32'd0);
            check("abort_after_valid", 32'(bv_a), 32'd0);
        end

        // Loopback sweep of all patterns, two frames each, both instances.
        for (int p = 0; p < 16; p++) begin
            send(1'b0, 4'(p), 4'd1, 1'b0, 11);
            send(1'b1, 4'(p), 4'd1, 1'b0, 9);
        end

        // Randomized transactions against the model.
        for (int r = 0; r < 30; r++) begin
            bit         s;
            logic [3:0] p;
            logic [3:0] n;
            bit         c;
            s = 1'($urandom_range(0, 1));
            p = 4'($urandom_range(0, 15));
            n = 4'($urandom_range(0, 4));
            c = 1'($urandom_range(0, 1));
            send(s, p, n, c, (int'(n) + 1) * 4 + int'(n) * (s ? 0 : 2) + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
